// File: rtl/gaussian_seq_ctrl.sv
// Frame sequencer for the 3x3 Gaussian blur: raster-order source reads, window shift/valid
// strobes, and destination writes delayed by the kernel pipeline latency.
module gaussian_seq_ctrl #(
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int ADDR_W     = 12,
  parameter int KERNEL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              win_shift,
  output logic              win_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  // Every kernel stage except the last; the last one fires in the cycle we leave DRAIN.
  localparam logic [KERNEL_LAT-1:0] NONFINAL = KERNEL_LAT'((1 << (KERNEL_LAT - 1)) - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              rd_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              s1_shift;
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [KERNEL_LAT-1:0] kv;
  logic [ADDR_W-1:0] ka [KERNEL_LAT];
  logic              done_q;
  logic              busy_q;
  logic              adv;
  logic              last_px;
  logic              interior;
  logic              pipe_empty;

  assign adv        = !stall || (state == IDLE);
  assign last_px    = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
  assign interior   = (row >= RW'(2)) && (col >= CW'(2));
  assign pipe_empty = !s1_shift && ((kv & NONFINAL) == '0);

  // Strobes are held in registers and masked while stalled, so a frozen
  // transfer fires in the first cycle after stall drops.
  assign rd_en     = rd_q & ~stall;
  assign win_shift = s1_shift & ~stall;
  assign win_valid = s1_valid & ~stall;
  assign wr_en     = kv[KERNEL_LAT-1] & ~stall;
  assign done      = done_q & ~stall;
  assign busy      = busy_q;
  assign rd_addr   = rd_addr_q;
  assign wr_addr   = ka[KERNEL_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      rd_q      <= 1'b0;
      rd_addr_q <= '0;
      s1_shift  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      kv        <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < KERNEL_LAT; i++) ka[i] <= '0;
    end else if (adv) begin
      s1_shift <= rd_q;
      s1_valid <= rd_q && interior;
      // Window centre is one row up and one column left of the newest pixel.
      if (rd_q && interior) s1_addr <= rd_addr_q - ADDR_W'(IMG_W + 1);
      kv[0] <= s1_valid;
      if (s1_valid) ka[0] <= s1_addr;
      for (int i = 1; i < KERNEL_LAT; i++) begin
        kv[i] <= kv[i-1];
        if (kv[i-1]) ka[i] <= ka[i-1];
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= READ;
            busy_q    <= 1'b1;
            rd_q      <= 1'b1;
            rd_addr_q <= '0;
            row       <= '0;
            col       <= '0;
          end
        end
        READ: begin
          if (last_px) begin
            rd_q  <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
            if (col == CW'(IMG_W - 1)) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gaussian_seq_ctrl.sv
// Directed bench for gaussian_seq_ctrl on an 8x6 image with a 3-cycle kernel.
// Cycle n of a frame is the n-th clock period after the edge that samples start.
module tb_gaussian_seq_ctrl;

  localparam int W   = 8;
  localparam int H   = 6;
  localparam int AW  = 12;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          busy, done, rd_en, win_shift, win_valid, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;

  gaussian_seq_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .KERNEL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .win_shift(win_shift), .win_valid(win_valid),
    .wr_en(wr_en), .wr_addr(wr_addr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc_abs = 0;
  int base    = 0;
  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  int rd_cnt, first_rd_cyc, first_rd_addr, last_rd_cyc;
  int wr_cnt, first_wr_cyc, first_wr_addr, last_wr_cyc, last_wr_addr;
  int wv_cnt, done_cnt, done_cyc, busy_cnt, busy_first, busy_last;
  int after_done_cyc, after_done_addr, exp_rd, rel, saved_busy;
  logic last_rd;
  logic [AW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rel_now();
    return cyc_abs - base;
  endfunction

  task automatic clear_stats();
    rd_cnt = 0; first_rd_cyc = -1; first_rd_addr = -1; last_rd_cyc = -1;
    wr_cnt = 0; first_wr_cyc = -1; first_wr_addr = -1; last_wr_cyc = -1; last_wr_addr = -1;
    wv_cnt = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0; busy_first = -1; busy_last = -1;
    after_done_cyc = -1; after_done_addr = -1; exp_rd = 0; last_rd = 1'b0;
    exp_q.delete();
    base = cyc_abs;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    clear_stats();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int limit);
    while (done_cnt < n && rel_now() < limit) step();
    step();
  endtask

  // ---------------- monitor: sampled on the falling edge ----------------
  always @(negedge clk) begin
    rel = cyc_abs - base;
    if (rst) begin
      last_rd = 1'b0;
    end else begin
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
      end
      if (done) begin
        done_cnt++;
        done_cyc = rel;
      end
      if (stall) begin
        check("stall_strobes", {29'd0, rd_en, win_shift, wr_en}, 32'd0);
      end else begin
        check("win_shift_delay", win_shift, last_rd);
        last_rd = rd_en;
        if (rd_en) begin
          rd_cnt++;
          if (first_rd_cyc < 0) begin
            first_rd_cyc  = rel;
            first_rd_addr = rd_addr;
          end
          last_rd_cyc = rel;
          if (done_cnt > 0 && after_done_cyc < 0) begin
            after_done_cyc  = rel;
            after_done_addr = rd_addr;
          end
          check("rd_addr_seq", rd_addr, exp_rd);
          if ((exp_rd / W) >= 2 && (exp_rd % W) >= 2) exp_q.push_back(AW'(exp_rd - W - 1));
          exp_rd = (exp_rd + 1) % (W * H);
        end
        if (win_shift && win_valid) wv_cnt++;
        if (wr_en) begin
          wr_cnt++;
          if (first_wr_cyc < 0) begin
            first_wr_cyc  = rel;
            first_wr_addr = wr_addr;
          end
          last_wr_cyc  = rel;
          last_wr_addr = wr_addr;
          check("wr_interior", (wr_addr / W >= 1) && (wr_addr / W <= H - 2) &&
                               (wr_addr % W >= 1) && (wr_addr % W <= W - 2), 1);
          check("wr_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("wr_addr_order", wr_addr, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    clear_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_win_shift", win_shift, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) step();

    // Frame A: stall-free, extra start pulses at cycles 10 and 30 are ignored
    pulse_start();
    while (done_cnt == 0 && rel_now() < 200) begin
      step();
      start = (rel_now() == 10 || rel_now() == 30);
    end
    start = 1'b0;
    while (rel_now() < 59) step();
    check("A_rd_cnt", rd_cnt, 48);
    check("A_first_rd_cyc", first_rd_cyc, 1);
    check("A_first_rd_addr", first_rd_addr, 0);
    check("A_last_rd_cyc", last_rd_cyc, 48);
    check("A_wr_cnt", wr_cnt, 24);
    check("A_first_wr_cyc", first_wr_cyc, 23);
    check("A_first_wr_addr", first_wr_addr, 9);
    check("A_last_wr_cyc", last_wr_cyc, 52);
    check("A_last_wr_addr", last_wr_addr, 38);
    check("A_win_valid_cnt", wv_cnt, 24);
    check("A_done_cnt", done_cnt, 1);
    check("A_done_cyc", done_cyc, 53);
    check("A_busy_cnt", busy_cnt, 53);
    check("A_busy_first", busy_first, 1);
    check("A_busy_last", busy_last, 53);
    check("A_queue_empty", exp_q.size(), 0);

    // Frame B: start at cycle 60 of frame A, stall during its cycles 20..24
    step();
    pulse_start();
    while (done_cnt == 0 && rel_now() < 200) begin
      step();
      stall = (rel_now() >= 20 && rel_now() <= 24);
    end
    stall = 1'b0;
    step();
    check("B_first_rd_cyc", first_rd_cyc, 1);
    check("B_first_rd_addr", first_rd_addr, 0);
    check("B_rd_cnt", rd_cnt, 48);
    check("B_last_rd_cyc", last_rd_cyc, 53);
    check("B_wr_cnt", wr_cnt, 24);
    check("B_last_wr_cyc", last_wr_cyc, 57);
    check("B_last_wr_addr", last_wr_addr, 38);
    check("B_win_valid_cnt", wv_cnt, 24);
    check("B_done_cyc", done_cyc, 58);
    check("B_busy_cnt", busy_cnt, 58);
    check("B_queue_empty", exp_q.size(), 0);

    // Frame C: asynchronous reset in cycle 25 aborts the frame
    repeat (2) step();
    pulse_start();
    while (rel_now() < 25) step();
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_rd_en", rd_en, 0);
    check("abort_win_shift", win_shift, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_rd_addr", rd_addr, 0);
    check("abort_wr_addr", wr_addr, 0);
    saved_busy = busy_cnt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) step();
    check("abort_no_done", done_cnt, 0);
    check("abort_busy_stays_low", busy_cnt, saved_busy);

    // Frame D: clean frame after the abort
    pulse_start();
    wait_done(1, 200);
    check("D_rd_cnt", rd_cnt, 48);
    check("D_wr_cnt", wr_cnt, 24);
    check("D_first_wr_addr", first_wr_addr, 9);
    check("D_last_wr_addr", last_wr_addr, 38);
    check("D_done_cyc", done_cyc, 53);
    check("D_busy_cnt", busy_cnt, 53);

    // Frame E: start held high gives back-to-back frames
    step();
    clear_stats();
    start = 1'b1;
    while (after_done_cyc < 0 && rel_now() < 200) step();
    start = 1'b0;
    check("E_first_done_cyc", done_cyc, 53);
    check("E_restart_cyc", after_done_cyc, 55);
    check("E_restart_addr", after_done_addr, 0);
    wait_done(2, 300);
    check("E_done_cnt", done_cnt, 2);
    check("E_rd_cnt", rd_cnt, 96);
    check("E_wr_cnt", wr_cnt, 48);
    check("E_second_done_cyc", done_cyc, 107);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
